// File: rtl/alu_resp.sv
`default_nettype none
// ============================================================================
// Module   : alu_resp
// Brief    : Handshaked ALU responder. Requests (s, a, b) enter a 2-entry
//            FIFO through a valid/ready input channel. Results leave through a
//            registered valid/ready output stage, in request order, and
//            resp_count counts the deliveries.
//            Optional macro ALU_RESP_CARRY_EN adds a registered carry/borrow
//            output.
// Revision : 1.0 - initial release
// ============================================================================
module alu_resp #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   s,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic [7:0]   resp_count
`ifdef ALU_RESP_CARRY_EN
    ,
    output logic         carry
`endif
);

    // A FIFO entry holds the raw request; the ALU runs on the head entry.
    localparam int W = 3 + 2 * N;

    logic [W-1:0] r_mem [2];
    logic         r_wptr;
    logic         r_rptr;
    logic [1:0]   r_count;
    logic         r_out_valid;
    logic [N-1:0] r_c;
    logic [7:0]   r_resp_count;

    logic         w_full;
    logic         w_empty;
    logic         w_push;
    logic         w_pop;
    logic         w_deliver;
    logic [W-1:0] w_head;
    logic [2:0]   w_hs;
    logic [N-1:0] w_ha;
    logic [N-1:0] w_hb;
    logic [N-1:0] w_res;

    assign w_full    = (r_count == 2'd2);
    assign w_empty   = (r_count == 2'd0);
    // in_ready comes from registered occupancy only, so a pop on the same
    // edge never opens the input channel combinationally.
    assign in_ready  = !w_full;
    assign w_push    = in_valid && !w_full;
    // The output stage reloads when it is empty or is being emptied now.
    assign w_pop     = !w_empty && (!r_out_valid || out_ready);
    assign w_deliver = r_out_valid && out_ready;

    assign w_head = r_mem[r_rptr];
    assign w_hs   = w_head[W-1 -: 3];
    assign w_ha   = w_head[2*N-1 -: N];
    assign w_hb   = w_head[N-1:0];

    // ALU result for the FIFO head entry.
    always_comb begin
        w_res = '0;
        case (w_hs)
            3'b000:  w_res = w_ha + w_hb;
            3'b001:  w_res = w_ha - w_hb;
            3'b010:  w_res = w_ha & w_hb;
            3'b011:  w_res = w_ha | w_hb;
            3'b100:  w_res = w_ha ^ w_hb;
            3'b101:  w_res = ~w_ha;
            3'b110:  w_res = {w_ha[N-2:0], 1'b0};
            default: w_res = {1'b0, w_ha[N-1:1]};
        endcase
    end

`ifdef ALU_RESP_CARRY_EN
    logic w_cy;
    logic r_carry;

    // Carry/borrow for the head entry; an N-bit sum wrapped below a means
    // the addition overflowed.
    always_comb begin
        w_cy = 1'b0;
        case (w_hs)
            3'b000:  w_cy = (w_res < w_ha);
            3'b001:  w_cy = (w_ha < w_hb);
            3'b110:  w_cy = w_ha[N-1];
            3'b111:  w_cy = w_ha[0];
            default: w_cy = 1'b0;
        endcase
    end

    // Carry register moves in lockstep with c.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_carry <= 1'b0;
        end else if (w_pop) begin
            r_carry <= w_cy;
        end
    end

    assign carry = r_carry;
`endif

    // FIFO storage: no reset needed, occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wptr] <= {s, a, b};
        end
    end

    // FIFO pointers/occupancy, output register and delivery counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr       <= 1'b0;
            r_rptr       <= 1'b0;
            r_count      <= 2'd0;
            r_out_valid  <= 1'b0;
            r_c          <= '0;
            r_resp_count <= 8'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr      <= ~r_rptr;
                r_c         <= w_res;
                r_out_valid <= 1'b1;
            end else if (w_deliver) begin
                r_out_valid <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
            if (w_deliver) begin
                r_resp_count <= r_resp_count + 8'd1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign c          = r_c;
    assign resp_count = r_resp_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_resp
// Brief    : Self-checking bench for alu_resp (N=4). A queue-based reference
//            model checks every cycle; directed scenarios add literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_resp;

    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   s;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic [7:0]   resp_count;
`ifdef ALU_RESP_CARRY_EN
    logic         carry;
`endif

    alu_resp #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .s          (s),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .c          (c),
        .resp_count (resp_count)
`ifdef ALU_RESP_CARRY_EN
        ,
        .carry      (carry)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int stalls = 0;
    int delivered_total = 0;

    logic [N:0]   exp_q[$];
    logic [N-1:0] got_c[$];
    logic         got_cy[$];
    int           got_cyc[$];

    logic         prev_stall = 1'b0;
    logic [N-1:0] prev_c;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cycle);
        end
    endtask

    // Reference ALU in plain integer arithmetic: returns {carry, result}.
    function automatic logic [N:0] model(input logic [2:0] op, input int av, input int bv);
        int m;
        int r;
        logic cy;
        m  = 1 << N;
        cy = 1'b0;
        case (op)
            3'd0: begin r = av + bv; cy = (r >= m); r = r % m; end
            3'd1: begin r = (av - bv + m) % m; cy = (av < bv); end
            3'd2: r = av & bv;
            3'd3: r = av | bv;
            3'd4: r = av ^ bv;
            3'd5: r = (m - 1) - av;
            3'd6: begin r = (av * 2) % m; cy = (av >= m / 2); end
            default: begin r = av / 2; cy = (av % 2 == 1); end
        endcase
        return {cy, r[N-1:0]};
    endfunction

    always @(posedge clk) cycle <= cycle + 1;

    // Per-cycle comparison against the model; samples mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            delivered_total = 0;
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", {31'd0, in_ready},
                {31'd0, (exp_q.size() - (out_valid ? 1 : 0)) < 2});
            chk("resp_count", {24'd0, resp_count}, delivered_total % 256);
            if (prev_stall) begin
                chk("stall_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_c", {28'd0, c}, {28'd0, prev_c});
            end
            if (out_valid && exp_q.size() == 0) begin
                chk("spurious_valid", 32'd1, 32'd0);
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                logic [N:0] e;
                e = exp_q.pop_front();
                chk("c", {28'd0, c}, {28'd0, e[N-1:0]});
`ifdef ALU_RESP_CARRY_EN
                chk("carry", {31'd0, carry}, {31'd0, e[N]});
                got_cy.push_back(carry);
`else
                got_cy.push_back(1'b0);
`endif
                got_c.push_back(c);
                got_cyc.push_back(cycle);
                delivered_total++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(s, int'(a), int'(b)));
            end
            prev_stall = out_valid && !out_ready;
            prev_c     = c;
        end
    end

    task automatic clear_got();
        got_c.delete();
        got_cy.delete();
        got_cyc.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one request and hold it until accepted (bounded).
    task automatic send(input logic [2:0] ts, input logic [N-1:0] ta, input logic [N-1:0] tb_v);
        int  waits;
        logic acc;
        in_valid = 1'b1;
        s = ts;
        a = ta;
        b = tb_v;
        waits = 0;
        acc = 1'b0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (!acc) begin
                waits++;
                stalls++;
            end
        end while (!acc && waits < 50);
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    logic [2:0]   ts3[5];
    logic [N-1:0] ta3[5];
    logic [N-1:0] tb3[5];
    int acc3;

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        s = '0;
        a = '0;
        b = '0;

        // Model pinned by hand-computed values.
        chk("model_add", {27'd0, model(3'd0, 9, 10)}, {27'd0, 5'b1_0011});
        chk("model_sub", {27'd0, model(3'd1, 4, 8)}, {27'd0, 5'b1_1100});
        chk("model_shr", {27'd0, model(3'd7, 6, 0)}, {27'd0, 5'b0_0011});

        idle(2);
        rst = 1'b0;

        // Reset state.
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_c", {28'd0, c}, 32'd0);
        chk("rst_resp_count", {24'd0, resp_count}, 32'd0);
        @(posedge clk);
        #1;

        // Single request, minimum latency of 2 edges.
        send(3'b000, 4'b1001, 4'b1010);
        @(negedge clk);
        chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        chk("lat_valid", {31'd0, out_valid}, 32'd1);
        chk("lat_c", {28'd0, c}, 32'b0011);
`ifdef ALU_RESP_CARRY_EN
        chk("lat_carry", {31'd0, carry}, 32'd1);
`endif
        @(negedge clk);
        chk("lat_count", {24'd0, resp_count}, 32'd1);
        chk("lat_drained", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Back-to-back requests leave on consecutive cycles, in order.
        clear_got();
        send(3'b001, 4'b0100, 4'b1000);
        send(3'b100, 4'b1110, 4'b0111);
        send(3'b111, 4'b0110, 4'b0000);
        idle(6);
        chk("b2b_n", got_c.size(), 32'd3);
        if (got_c.size() >= 3) begin
            chk("b2b_0", {28'd0, got_c[0]}, 32'b1100);
            chk("b2b_1", {28'd0, got_c[1]}, 32'b1001);
            chk("b2b_2", {28'd0, got_c[2]}, 32'b0011);
            chk("b2b_seq1", got_cyc[1], got_cyc[0] + 1);
            chk("b2b_seq2", got_cyc[2], got_cyc[1] + 1);
`ifdef ALU_RESP_CARRY_EN
            chk("b2b_cy0", {31'd0, got_cy[0]}, 32'd1);
`endif
        end

        // Back-pressure: exactly 3 of 5 offered requests are absorbed.
        clear_got();
        ts3 = '{3'b011, 3'b010, 3'b101, 3'b000, 3'b110};
        ta3 = '{4'd1, 4'd15, 4'd5, 4'd1, 4'd3};
        tb3 = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd0};
        out_ready = 1'b0;
        acc3 = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            s = ts3[i];
            a = ta3[i];
            b = tb3[i];
            @(negedge clk);
            if (in_ready) acc3++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("bp_accepted", acc3, 32'd3);
        @(negedge clk);
        chk("bp_full", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(6);
        chk("bp_n", got_c.size(), 32'd3);
        if (got_c.size() >= 3) begin
            chk("bp_0", {28'd0, got_c[0]}, 32'd3);
            chk("bp_1", {28'd0, got_c[1]}, 32'd6);
            chk("bp_2", {28'd0, got_c[2]}, 32'd10);
        end
        @(negedge clk);
        chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Push and pop on the same edge with one FIFO entry.
        clear_got();
        out_ready = 1'b0;
        send(3'b000, 4'd2, 4'd3);
        send(3'b001, 4'd3, 4'd5);
        out_ready = 1'b1;
        send(3'b100, 4'd12, 4'd10);
        out_ready = 1'b0;
        @(negedge clk);
        chk("pp_ready_1", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        send(3'b111, 4'd9, 4'd0);
        @(negedge clk);
        chk("pp_ready_2", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        idle(6);
        chk("pp_n", got_c.size(), 32'd4);
        if (got_c.size() >= 4) begin
            chk("pp_0", {28'd0, got_c[0]}, 32'd5);
            chk("pp_1", {28'd0, got_c[1]}, 32'd14);
            chk("pp_2", {28'd0, got_c[2]}, 32'd6);
            chk("pp_3", {28'd0, got_c[3]}, 32'd4);
        end

        // 256 deliveries at full throughput wrap resp_count to 0.
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        stalls = 0;
        for (int i = 0; i < 256; i++) begin
            send(3'(i % 8), 4'(i % 16), 4'((i * 7) % 16));
        end
        idle(6);
        chk("wrap_stalls", stalls, 32'd0);
        chk("wrap_total", delivered_total, 32'd256);
        @(negedge clk);
        chk("wrap_count", {24'd0, resp_count}, 32'd0);
        @(posedge clk);
        #1;

        // Reset while full with a pending result.
        out_ready = 1'b0;
        send(3'b000, 4'd1, 4'd1);
        send(3'b011, 4'd4, 4'd8);
        send(3'b010, 4'd7, 4'd3);
        in_valid = 1'b1;
        s = 3'b000;
        a = 4'd5;
        b = 4'd5;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_c", {28'd0, c}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_count", {24'd0, resp_count}, 32'd0);
`ifdef ALU_RESP_CARRY_EN
        chk("mid_rst_carry", {31'd0, carry}, 32'd0);
`endif
        @(posedge clk);
        #1;
        clear_got();
        out_ready = 1'b1;
        idle(5);
        chk("mid_rst_no_stale", got_c.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_resp.md
# alu_resp

Handshaked responder for the N-bit, 3-bit-opcode ALU command set. It accepts (s, a, b) requests on a valid/ready input channel and buffers them in a 2-entry FIFO. It returns each result c on a registered valid/ready output channel, in request order. It sits between any stimulus source (bench driver, LFSR generator, host interface) and downstream result consumers, and replaces the purely combinational ALU wherever back-pressure is needed.

## Interface
- N, default 4: operand and result width, N >= 2.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  request present on s/a/b.
- in_ready  output  1  responder can accept a request this cycle.
- s  input  3  opcode.
- a  input  N  operand A.
- b  input  N  operand B.
- out_valid  output  1  result present on c.
- out_ready  input  1  consumer accepts the result this cycle.
- c  output  N  result.
- resp_count  output  8  number of results delivered; wraps 255 -> 0.
- carry  output  1  carry/borrow of the result; present only with ALU_RESP_CARRY_EN.

## Operation
- Opcodes:
  - 000: a+b mod 2^N.
  - 001: a-b mod 2^N.
  - 010: a&b.
  - 011: a|b.
  - 100: a^b.
  - 101: ~a.
  - 110: a<<1, LSB 0.
  - 111: a>>1, MSB 0 (logical).
- Operand b is ignored for opcodes 101, 110 and 111.
- Push: a request is accepted on an edge where in_valid && in_ready. It is written to the FIFO tail.
- in_ready = !fifo_full. It depends only on registered state, never combinationally on out_ready.
- Pop/load: on an edge where the FIFO is non-empty and (!out_valid || out_ready), the head entry is popped. Its result is computed and registered into c, and out_valid is set to 1.
- Drain: on an edge where out_valid && out_ready and the FIFO is empty, out_valid clears. c holds its last value.
- Delivery: a result is delivered on each edge where out_valid && out_ready; resp_count increments by 1 on that edge.
- While out_valid=1 and out_ready=0, c and out_valid hold stable.
- Push and pop on the same edge are legal. Occupancy is unchanged.
- Full FIFO: in_ready=0 even if a pop occurs that edge. Requests offered while in_ready=0 are ignored (not accepted, not lost state).
- Empty FIFO with a free output stage: nothing loads, and out_valid stays or goes 0.
- FIFO read/write pointers are 1 bit each plus a 2-bit occupancy count. Pointers wrap 1 -> 0.

## Timing
- Reset values, all outputs:
  - in_ready=1
  - out_valid=0
  - c=0
  - resp_count=0
  - carry=0
  - FIFO empty, pointers 0.
- rst asserted mid-operation discards all buffered and pending results on that edge; in-flight handshakes on that edge are ignored.
- Latency: a request accepted at edge E0 into an empty FIFO with an idle output stage loads at E1. out_valid=1 is visible after E1, so the minimum latency is 2 edges.
- Throughput: 1 result per cycle sustained when out_ready=1 continuously.
- With out_ready=0, exactly 3 requests are absorbed (2 FIFO + 1 output register) before in_ready drops.
- Ordering: results leave in strict acceptance order.

## Configuration
- ALU_RESP_CARRY_EN defined: port carry exists. It is registered alongside c and holds under stall.
  - For 000: carry = bit N of the (N+1)-bit a+b.
  - For 001: carry = borrow, i.e. 1 when a<b unsigned.
  - For 110: carry = a[N-1].
  - For 111: carry = a[0].
  - All other opcodes: carry = 0.
- ALU_RESP_CARRY_EN undefined: no carry port, and no carry storage is carried in the FIFO or the output register.

## Test plan
- Reset then single request, N=4, s=000, a=1001, b=1010, out_ready=1 -> out_valid after 2 edges, c=0011, carry=1 (if enabled), resp_count=1.
- Back-to-back s=001 a=0100 b=1000, then s=100 a=1110 b=0111, then s=111 a=0110 -> c=1100 (carry=1), 1001, 0011 on consecutive cycles, in order.
- Hold out_ready=0, offer 5 requests -> exactly 3 accepted, then in_ready=0. Release out_ready -> 3 results in order, then in_ready returns to 1.
- Simultaneous push/pop with FIFO at 1 entry -> occupancy stays 1, no result skipped or duplicated.
- Deliver 256 results -> resp_count wraps to 0.
- Assert rst while FIFO full and out_valid=1 -> next cycle out_valid=0, c=0, in_ready=1, resp_count=0; no stale result is emitted afterwards.
